// File: rtl/fpdiv_sched.sv
// fpdiv_sched: round-robin scheduler sharing one fpdiv unit between two requesters.
// Ports:
//   clk, reset_n                 clock, async active-low reset
//   req_valid/req_ready [1:0]    request handshake (req_ready combinational, IDLE only)
//   req_op[3:0], req_rm[1:0]     per-requester op (00 div, 01 sqrt, 1x illegal) and rounding
//   req_a/req_b [2*WIDTH-1:0]    per-requester operands
//   resp_valid/resp_ready [1:0]  response handshake towards the owning requester
//   resp_result, resp_err        registered response payload
//   unit_start, unit_op, unit_round_mode, unit_a, unit_b   drive to the fpdiv unit
//   unit_result, unit_done       unit completion
//   busy                         FSM not idle
module fpdiv_sched #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [1:0]         req_valid,
  output logic [1:0]         req_ready,
  input  logic [3:0]         req_op,
  input  logic [1:0]         req_rm,
  input  logic [2*WIDTH-1:0] req_a,
  input  logic [2*WIDTH-1:0] req_b,
  output logic [1:0]         resp_valid,
  input  logic [1:0]         resp_ready,
  output logic [WIDTH-1:0]   resp_result,
  output logic               resp_err,
  output logic               unit_start,
  output logic [1:0]         unit_op,
  output logic               unit_round_mode,
  output logic [WIDTH-1:0]   unit_a,
  output logic [WIDTH-1:0]   unit_b,
  input  logic [WIDTH-1:0]   unit_result,
  input  logic               unit_done,
  output logic               busy
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [WIDTH-1:0] QNAN = WIDTH'(32'h7FC0_0000);

  typedef enum logic [1:0] {IDLE, ISSUE, BUSY, RESP} state_e;

  state_e             state_q, state_d;
  logic               last_grant_q, last_grant_d;
  logic               owner_q, owner_d;
  logic               unit_start_q, unit_start_d;
  logic [1:0]         unit_op_q, unit_op_d;
  logic               unit_rm_q, unit_rm_d;
  logic [WIDTH-1:0]   unit_a_q, unit_a_d;
  logic [WIDTH-1:0]   unit_b_q, unit_b_d;
  logic [1:0]         resp_valid_q, resp_valid_d;
  logic [WIDTH-1:0]   resp_result_q, resp_result_d;
  logic               resp_err_q, resp_err_d;
  logic               busy_q, busy_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic               gnt_idx_c;
  logic [1:0]         gnt_c;
  logic               accept_c;
  logic [1:0]         sel_op_c;
  logic               sel_rm_c;
  logic [WIDTH-1:0]   sel_a_c, sel_b_c;
  logic               op_legal_c;
  logic [CNT_W-1:0]   cnt_inc_c;
  logic               timeout_c;

  // Arbitration: on a tie grant the requester that was not served last.
  always_comb begin
    gnt_idx_c = 1'b0;
    if (req_valid == 2'b11) gnt_idx_c = ~last_grant_q;
    else if (req_valid[1])  gnt_idx_c = 1'b1;
    gnt_c = 2'b00;
    if (state_q == IDLE && (|req_valid)) gnt_c = {gnt_idx_c, ~gnt_idx_c};
    accept_c   = |gnt_c;
    sel_op_c   = gnt_idx_c ? req_op[3:2] : req_op[1:0];
    sel_rm_c   = req_rm[gnt_idx_c];
    sel_a_c    = gnt_idx_c ? req_a[2*WIDTH-1:WIDTH] : req_a[WIDTH-1:0];
    sel_b_c    = gnt_idx_c ? req_b[2*WIDTH-1:WIDTH] : req_b[WIDTH-1:0];
    op_legal_c = ~sel_op_c[1];
  end

  // Watchdog fires on the cycle the incremented count would reach TIMEOUT.
  always_comb begin
    cnt_inc_c = cnt_q + CNT_W'(1);
    timeout_c = (state_q == BUSY) && (cnt_inc_c == CNT_W'(TIMEOUT));
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept_c) state_d = op_legal_c ? ISSUE : RESP;
      ISSUE:   state_d = BUSY;
      BUSY:    if (unit_done || timeout_c) state_d = RESP;
      RESP:    if (resp_ready[owner_q]) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output and datapath next values.
  always_comb begin
    last_grant_d  = last_grant_q;
    owner_d       = owner_q;
    unit_start_d  = 1'b0;
    unit_op_d     = unit_op_q;
    unit_rm_d     = unit_rm_q;
    unit_a_d      = unit_a_q;
    unit_b_d      = unit_b_q;
    resp_valid_d  = resp_valid_q;
    resp_result_d = resp_result_q;
    resp_err_d    = resp_err_q;
    cnt_d         = cnt_q;
    busy_d        = (state_d != IDLE);
    case (state_q)
      IDLE: begin
        if (accept_c) begin
          owner_d      = gnt_idx_c;
          last_grant_d = gnt_idx_c;
          if (op_legal_c) begin
            unit_start_d = 1'b1;
            unit_op_d    = sel_op_c;
            unit_rm_d    = sel_rm_c;
            unit_a_d     = sel_a_c;
            unit_b_d     = sel_b_c;
          end else begin
            // Illegal op never reaches the unit; answer immediately.
            resp_valid_d  = {gnt_idx_c, ~gnt_idx_c};
            resp_result_d = QNAN;
            resp_err_d    = 1'b1;
          end
        end
      end
      ISSUE: cnt_d = '0;
      BUSY: begin
        cnt_d = cnt_inc_c;
        if (unit_done) begin
          resp_valid_d  = {owner_q, ~owner_q};
          resp_result_d = unit_result;
          resp_err_d    = 1'b0;
        end else if (timeout_c) begin
          resp_valid_d  = {owner_q, ~owner_q};
          resp_result_d = QNAN;
          resp_err_d    = 1'b1;
        end
      end
      RESP: if (resp_ready[owner_q]) resp_valid_d = 2'b00;
      default: ;
    endcase
  end

  // Registered outputs and operation context.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_grant_q  <= 1'b1;
      owner_q       <= 1'b0;
      unit_start_q  <= 1'b0;
      unit_op_q     <= 2'b00;
      unit_rm_q     <= 1'b0;
      unit_a_q      <= '0;
      unit_b_q      <= '0;
      resp_valid_q  <= 2'b00;
      resp_result_q <= '0;
      resp_err_q    <= 1'b0;
      busy_q        <= 1'b0;
      cnt_q         <= '0;
    end else begin
      last_grant_q  <= last_grant_d;
      owner_q       <= owner_d;
      unit_start_q  <= unit_start_d;
      unit_op_q     <= unit_op_d;
      unit_rm_q     <= unit_rm_d;
      unit_a_q      <= unit_a_d;
      unit_b_q      <= unit_b_d;
      resp_valid_q  <= resp_valid_d;
      resp_result_q <= resp_result_d;
      resp_err_q    <= resp_err_d;
      busy_q        <= busy_d;
      cnt_q         <= cnt_d;
    end
  end

  assign req_ready       = gnt_c;
  assign resp_valid      = resp_valid_q;
  assign resp_result     = resp_result_q;
  assign resp_err        = resp_err_q;
  assign unit_start      = unit_start_q;
  assign unit_op         = unit_op_q;
  assign unit_round_mode = unit_rm_q;
  assign unit_a          = unit_a_q;
  assign unit_b          = unit_b_q;
  assign busy            = busy_q;

endmodule

// File: tb/tb_fpdiv_sched.sv
// tb_fpdiv_sched: directed self-checking bench for fpdiv_sched with a small
// latency-programmable fpdiv unit model.
module tb_fpdiv_sched;

  localparam int unsigned WIDTH = 32;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic [1:0]        req_valid = 2'b00;
  logic [1:0]        req_ready;
  logic [3:0]        req_op = 4'b0000;
  logic [1:0]        req_rm = 2'b00;
  logic [63:0]       req_a = '0;
  logic [63:0]       req_b = '0;
  logic [1:0]        resp_valid;
  logic [1:0]        resp_ready = 2'b00;
  logic [31:0]       resp_result;
  logic              resp_err;
  logic              unit_start;
  logic [1:0]        unit_op;
  logic              unit_round_mode;
  logic [31:0]       unit_a;
  logic [31:0]       unit_b;
  logic [31:0]       unit_result = '0;
  logic              unit_done = 1'b0;
  logic              busy;

  // Unit model controls (written by the stimulus block only).
  bit          m_en = 1'b1;
  int          m_lat = 10;
  logic [31:0] m_res = '0;
  bit          m_force = 1'b0;
  logic [31:0] m_force_res = '0;
  int          m_cnt = 0;

  int passed = 0;
  int total = 0;

  fpdiv_sched #(.WIDTH(WIDTH), .TIMEOUT(64)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_rm(req_rm), .req_a(req_a), .req_b(req_b),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_result(resp_result), .resp_err(resp_err),
    .unit_start(unit_start), .unit_op(unit_op), .unit_round_mode(unit_round_mode),
    .unit_a(unit_a), .unit_b(unit_b),
    .unit_result(unit_result), .unit_done(unit_done),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Unit model: done strobe L cycles after the start cycle; m_force injects a stray strobe.
  always @(negedge clk) begin
    unit_done = 1'b0;
    if (m_cnt > 0) begin
      m_cnt = m_cnt - 1;
      if (m_cnt == 0) begin
        unit_done   = 1'b1;
        unit_result = m_res;
      end
    end
    if (m_force) begin
      unit_done   = 1'b1;
      unit_result = m_force_res;
    end
    if (unit_start && m_en) m_cnt = m_lat;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  initial begin
    // Reset values
    step(); step();
    check("rst_req_ready", 64'(req_ready), 64'h0);
    check("rst_resp_valid", 64'(resp_valid), 64'h0);
    check("rst_resp_result", 64'(resp_result), 64'h0);
    check("rst_resp_err", 64'(resp_err), 64'h0);
    check("rst_unit_start", 64'(unit_start), 64'h0);
    check("rst_unit_op", 64'(unit_op), 64'h0);
    check("rst_unit_rm", 64'(unit_round_mode), 64'h0);
    check("rst_unit_ab", {unit_a, unit_b}, 64'h0);
    check("rst_busy", 64'(busy), 64'h0);
    reset_n = 1'b1;
    step();

    // Contention: sqrt(16.0) from both, strict alternation 0,1,0,1
    m_lat = 3; m_res = 32'h4080_0000;
    req_op = 4'b0101; req_rm = 2'b10;
    req_a = {32'h4180_0000, 32'h4180_0000}; req_b = '0;
    req_valid = 2'b11;
    for (int r = 0; r < 4; r++) begin
      logic [1:0] oh;
      oh = (r % 2 == 0) ? 2'b01 : 2'b10;
      resp_ready = 2'b00;
      #1;
      check("cont_grant", 64'(req_ready), 64'(oh));
      step();
      check("cont_start", 64'(unit_start), 64'h1);
      check("cont_op", 64'(unit_op), 64'h1);
      check("cont_rm", 64'(unit_round_mode), (r % 2 == 0) ? 64'h0 : 64'h1);
      step(); step(); step(); step();
      check("cont_resp_valid", 64'(resp_valid), 64'(oh));
      check("cont_result", 64'(resp_result), 64'h4080_0000);
      check("cont_err", 64'(resp_err), 64'h0);
      resp_ready = 2'b11;
      if (r == 3) req_valid = 2'b00;
      step();
    end
    resp_ready = 2'b00;

    // Single div 3.0 / 1.0, latency 10
    m_lat = 10; m_res = 32'h4040_0000;
    req_op = 4'b1100; req_rm = 2'b00;
    req_a = {32'h1111_1111, 32'h4040_0000};
    req_b = {32'h2222_2222, 32'h3F80_0000};
    req_valid = 2'b01;
    #1;
    check("div_req_ready", 64'(req_ready), 64'h1);
    step();
    req_valid = 2'b00; req_a = '1; req_b = '1;
    check("div_start", 64'(unit_start), 64'h1);
    check("div_unit_ab", {unit_a, unit_b}, 64'h4040_0000_3F80_0000);
    check("div_unit_op", 64'(unit_op), 64'h0);
    check("div_busy", 64'(busy), 64'h1);
    check("div_ready_busy", 64'(req_ready), 64'h0);
    step();
    check("div_start_once", 64'(unit_start), 64'h0);
    for (int i = 3; i <= 11; i++) step();
    check("div_resp_early", 64'(resp_valid), 64'h0);
    step();
    check("div_resp_valid", 64'(resp_valid), 64'h1);
    check("div_result", 64'(resp_result), 64'h4040_0000);
    check("div_err", 64'(resp_err), 64'h0);
    resp_ready = 2'b01;
    step();
    resp_ready = 2'b00;
    check("div_resp_done", 64'(resp_valid), 64'h0);
    check("div_idle", 64'(busy), 64'h0);

    // Illegal op from requester 1
    req_op = 4'b1000; req_valid = 2'b10;
    #1;
    check("ill_req_ready", 64'(req_ready), 64'h2);
    step();
    req_valid = 2'b00; req_op = 4'b0000;
    check("ill_resp_valid", 64'(resp_valid), 64'h2);
    check("ill_result", 64'(resp_result), 64'h7FC0_0000);
    check("ill_err", 64'(resp_err), 64'h1);
    check("ill_no_start", 64'(unit_start), 64'h0);
    resp_ready = 2'b10;
    step();
    resp_ready = 2'b00;
    check("ill_no_start2", 64'(unit_start), 64'h0);
    check("ill_resp_done", 64'(resp_valid), 64'h0);

    // Timeout: unit never completes
    m_en = 1'b0;
    req_a = {32'h0, 32'h4040_0000}; req_b = {32'h0, 32'h3F80_0000};
    req_valid = 2'b01;
    step();
    req_valid = 2'b00;
    check("to_start", 64'(unit_start), 64'h1);
    for (int i = 2; i <= 65; i++) step();
    check("to_resp_early", 64'(resp_valid), 64'h0);
    step();
    check("to_resp_valid", 64'(resp_valid), 64'h1);
    check("to_result", 64'(resp_result), 64'h7FC0_0000);
    check("to_err", 64'(resp_err), 64'h1);
    resp_ready = 2'b01;
    step();
    resp_ready = 2'b00;
    check("to_busy", 64'(busy), 64'h0);
    m_en = 1'b1;

    // Response backpressure on requester 1, with stray done strobes
    m_lat = 4; m_res = 32'h3F00_0000;
    req_op = 4'b0000; req_valid = 2'b10;
    step();
    req_valid = 2'b00;
    for (int i = 2; i <= 6; i++) step();
    check("bp_resp_valid", 64'(resp_valid), 64'h2);
    check("bp_result", 64'(resp_result), 64'h3F00_0000);
    m_force_res = 32'hDEAD_BEEF;
    resp_ready = 2'b01;
    req_valid = 2'b11;
    for (int i = 0; i < 20; i++) begin
      m_force = (i == 5) || (i == 12);
      #1;
      check("bp_ready_low", 64'(req_ready), 64'h0);
      step();
      check("bp_hold_valid", 64'(resp_valid), 64'h2);
      check("bp_hold_result", 64'(resp_result), 64'h3F00_0000);
    end
    m_force = 1'b0;
    req_valid = 2'b00;
    resp_ready = 2'b10;
    step();
    resp_ready = 2'b00;
    check("bp_resp_done", 64'(resp_valid), 64'h0);
    check("bp_idle", 64'(busy), 64'h0);

    // Reset during BUSY
    m_lat = 10; m_res = 32'h4040_0000;
    req_valid = 2'b01;
    step();
    req_valid = 2'b00;
    check("rb_start", 64'(unit_start), 64'h1);
    for (int i = 0; i < 5; i++) step();
    reset_n = 1'b0;
    #1;
    check("rb_busy", 64'(busy), 64'h0);
    check("rb_resp_valid", 64'(resp_valid), 64'h0);
    check("rb_unit_ab", {unit_a, unit_b}, 64'h0);
    check("rb_unit_op", 64'(unit_op), 64'h0);
    check("rb_result", {31'h0, resp_err, resp_result}, 64'h0);
    step();
    reset_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      check("rb_no_resp", 64'(resp_valid), 64'h0);
    end
    check("rb_idle", 64'(busy), 64'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/fpdiv_sched.md
# fpdiv_sched

Round-robin scheduler that shares one `fpdiv` divide/square-root unit between two requesters. It accepts a request through a valid/ready handshake and issues it to the unit with a one-cycle start pulse. It then waits for the unit's done strobe and returns the result to the originating requester through a second valid/ready handshake. It sits between the FPU issue logic and the `fpdiv` instance and owns the unit's `op`, `round_mode` and operand inputs.

## Interface
- `WIDTH`, 32: operand/result width (binary32).
- `TIMEOUT`, 64: maximum cycles from `unit_start` to `unit_done` before the watchdog aborts the operation.
- `clk` in 1: clock, all state on rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `req_valid` in 2: request valid, bit i = requester i.
- `req_ready` out 2: request accepted when `req_valid[i] & req_ready[i]`.
- `req_op` in 4: 2 bits per requester; 00 = div, 01 = sqrt, 1x = illegal.
- `req_rm` in 2: rounding mode per requester; 0 = RNE, 1 = RZ.
- `req_a` in 2*WIDTH: dividend/radicand per requester.
- `req_b` in 2*WIDTH: divisor per requester (ignored for sqrt).
- `resp_valid` out 2: response valid, bit i = requester i; at most one bit set.
- `resp_ready` in 2: response consumed when `resp_valid[i] & resp_ready[i]`.
- `resp_result` out WIDTH: result, qualified by `resp_valid`.
- `resp_err` out 1: timeout or illegal op, qualified by `resp_valid`.
- `unit_start` out 1: one-cycle pulse launching the unit.
- `unit_op` out 2, `unit_round_mode` out 1, `unit_a`/`unit_b` out WIDTH: held stable from ISSUE through BUSY.
- `unit_result` in WIDTH, `unit_done` in 1: unit result and single-cycle completion strobe.
- `busy` out 1: state != IDLE.

## Operation
- FSM states: IDLE, ISSUE, BUSY, RESP.
- **IDLE**
  - Arbitrate among `req_valid`. If both are valid, grant the requester that is not `last_grant`; otherwise grant the only valid one.
  - `req_ready` is combinational and is high only for the granted bit. The other bit is 0.
  - On accept, capture op, rm, a and b into registers, record `owner`, and update `last_grant`.
  - If the op is legal, go to ISSUE. If the op is illegal, go directly to RESP with result 0x7FC00000 and err=1; the unit is not touched.
- **ISSUE**
  - `unit_start`=1 for exactly this cycle.
  - Clear the watchdog counter, then go to BUSY.
- **BUSY**
  - The counter increments each cycle.
  - If `unit_done`=1, capture `unit_result` with err=0 and go to RESP.
  - Else, if the counter reaches `TIMEOUT`, set result 0x7FC00000 with err=1 and go to RESP.
  - If `unit_done` and the timeout occur in the same cycle, `unit_done` wins.
- **RESP**
  - `resp_valid[owner]`=1, holding `resp_result` and `resp_err` stable until `resp_ready[owner]`=1, then go to IDLE.
  - `resp_ready` of the non-owner is ignored.
- `req_ready`=0 in every state except IDLE, so there is one operation in flight and no queueing.
- `unit_done` is ignored in IDLE, ISSUE and RESP (stale strobes from an aborted operation are dropped).
- Requester inputs are sampled only on the accept cycle; a requester may change them freely afterwards.
- Watchdog counter width: clog2(TIMEOUT+1).

## Timing
- Reset (async assert, synchronous release) sets:
  - state=IDLE, `last_grant`=1 (so requester 0 wins the first tie), `owner`=0;
  - `req_ready`=0 until the next arbitration evaluation, then combinational;
  - `resp_valid`=00, `resp_result`=0, `resp_err`=0;
  - `unit_start`=0, `unit_op`=00, `unit_round_mode`=0, `unit_a`=`unit_b`=0;
  - `busy`=0, counter=0.
- For an accept in cycle 0 with the unit done L cycles after start:
  - `unit_start` is high in cycle 1 and `unit_done` arrives in cycle 1+L.
  - `resp_valid` is high from cycle 2+L.
  - Next accept is possible in the cycle after the response handshake.
- Illegal op: accept in cycle 0, `resp_valid` in cycle 1.
- Timeout: `unit_start` in cycle 1, `resp_valid` with err in cycle 2+TIMEOUT.
- Reset mid-operation aborts immediately: any response is lost, and the unit may keep running, but its later `unit_done` is ignored in IDLE.
- A requester holding `req_valid` while the other is served is granted the next time the FSM is in IDLE. Strict alternation under continuous contention.

## Test plan
- **Single div:** requester 0 sends op=00, a=0x40400000 (3.0), b=0x3F800000 (1.0); unit model returns 0x40400000 with done after 10 cycles. Require:
  - `unit_start` exactly one cycle after accept, with `unit_a`/`unit_b` matching;
  - `resp_valid`=01 at accept+12, result 0x40400000, err=0.
- **Contention:** both requesters are valid continuously with sqrt of 0x41800000 (16.0) → 0x40800000. Require grants in order 0,1,0,1, each response routed to the correct `resp_valid` bit.
- **Illegal op:** requester 1 sends op=10. Require:
  - `resp_valid`=10 the next cycle, result 0x7FC00000, err=1;
  - `unit_start` never pulses.
- **Timeout:** the unit model never asserts done, TIMEOUT=64. Require `resp_valid` with err=1 at accept+66, result 0x7FC00000, `busy`=0 after the handshake.
- **Response backpressure:** `resp_ready` is held 0 for 20 cycles. Require `resp_result` stable, `req_ready`=00 throughout, and `unit_done` pulses during RESP ignored.
- **Reset mid-BUSY:** assert `reset_n`=0 five cycles after `unit_start`. Require all outputs at their reset values immediately, and a later `unit_done` producing no response.
